// File: rtl/multiplier_arbiter_if.sv
// Client and multiplier-side signals of the shared-multiplier arbiter.
interface multiplier_arbiter_if #(
  parameter int unsigned BITS       = 4,
  parameter int unsigned REQUESTERS = 4
);
  logic [REQUESTERS-1:0]      i_request;
  logic [REQUESTERS*BITS-1:0] i_multiplicand;
  logic [REQUESTERS*BITS-1:0] i_multiplier;
  logic [REQUESTERS-1:0]      o_grant;
  logic [REQUESTERS-1:0]      o_done;
  logic [REQUESTERS-1:0]      o_error;
  logic [2*BITS-1:0]          o_product;
  logic                       o_mul_start;
  logic [BITS-1:0]            o_mul_multiplicand;
  logic [BITS-1:0]            o_mul_multiplier;
  logic                       i_mul_finished;
  logic [2*BITS-1:0]          i_mul_product;

  // Clients plus the multiplier: drive requests/operands and the completion.
  modport master (
    output i_request, i_multiplicand, i_multiplier, i_mul_finished, i_mul_product,
    input  o_grant, o_done, o_error, o_product, o_mul_start,
           o_mul_multiplicand, o_mul_multiplier
  );

  // The arbiter itself.
  modport slave (
    input  i_request, i_multiplicand, i_multiplier, i_mul_finished, i_mul_product,
    output o_grant, o_done, o_error, o_product, o_mul_start,
           o_mul_multiplicand, o_mul_multiplier
  );
endinterface

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between several clients.
module multiplier_arbiter #(
  parameter int unsigned BITS       = 4,
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  multiplier_arbiter_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(REQUESTERS);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam int unsigned PW    = 2 * BITS;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [REQUESTERS-1:0] grant_q, grant_d;
  logic [REQUESTERS-1:0] done_q, done_d;
  logic [REQUESTERS-1:0] error_q, error_d;
  logic [PW-1:0]         product_q, product_d;
  logic                  start_q, start_d;
  logic [BITS-1:0]       mcand_q, mcand_d;
  logic [BITS-1:0]       mplier_q, mplier_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      winner_q, winner_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  arb_found_c;
  logic [IDX_W-1:0]      arb_win_c;
  logic [IDX_W-1:0]      arb_idx_c;
  logic                  timeout_c;

  // Round-robin pick: first asserted request scanning from the pointer upward.
  always_comb begin
    arb_found_c = 1'b0;
    arb_win_c   = '0;
    arb_idx_c   = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      arb_idx_c = IDX_W'((32'(ptr_q) + i) % REQUESTERS);
      if (!arb_found_c && bus.i_request[arb_idx_c]) begin
        arb_found_c = 1'b1;
        arb_win_c   = arb_idx_c;
      end
    end
  end

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register and datapath flops.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      error_q   <= '0;
      product_q <= '0;
      start_q   <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      ptr_q     <= '0;
      winner_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      error_q   <= error_d;
      product_q <= product_d;
      start_q   <= start_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (arb_found_c) state_d = S_START;
      S_START: state_d = S_BUSY;
      S_BUSY:  if (bus.i_mul_finished || timeout_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs and datapath updates; finished beats timeout.
  always_comb begin
    grant_d   = grant_q;
    done_d    = '0;
    error_d   = '0;
    product_d = product_q;
    start_d   = 1'b0;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (arb_found_c) begin
          grant_d  = REQUESTERS'(1) << arb_win_c;
          winner_d = arb_win_c;
          mcand_d  = bus.i_multiplicand[32'(arb_win_c) * BITS +: BITS];
          mplier_d = bus.i_multiplier[32'(arb_win_c) * BITS +: BITS];
          start_d  = 1'b1;
        end
      end
      S_START: cnt_d = '0;
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.i_mul_finished) begin
          product_d = bus.i_mul_product;
          done_d    = grant_q;
          grant_d   = '0;
        end else if (timeout_c) begin
          error_d = grant_q;
          grant_d = '0;
        end
      end
      S_DONE: begin
        grant_d = '0;
        ptr_d   = (winner_q == IDX_W'(REQUESTERS - 1)) ? '0 : winner_q + IDX_W'(1);
      end
      default: grant_d = '0;
    endcase
  end

  assign bus.o_grant            = grant_q;
  assign bus.o_done             = done_q;
  assign bus.o_error            = error_q;
  assign bus.o_product          = product_q;
  assign bus.o_mul_start        = start_q;
  assign bus.o_mul_multiplicand = mcand_q;
  assign bus.o_mul_multiplier   = mplier_q;
endmodule

// File: tb/tb_multiplier_arbiter.sv
// Scoreboard bench for multiplier_arbiter with a behavioural multiplier and arbitration model.
module tb_multiplier_arbiter;
  localparam int unsigned BITS = 4;
  localparam int unsigned REQ  = 4;
  localparam int unsigned TO   = 8;
  localparam int unsigned PW   = 2 * BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multiplier_arbiter_if #(.BITS(BITS), .REQUESTERS(REQ)) bus ();

  multiplier_arbiter #(.BITS(BITS), .REQUESTERS(REQ), .TIMEOUT(TO)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    int              client;
    bit              is_err;
    logic [PW-1:0]   prod;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   hang  = 1'b0;
  int   mdl_ptr = 0;
  logic [PW-1:0] mdl_last = '0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural multiplier: fixed random latency after a start, optional hang, stray pulses when idle.
  initial begin
    int cnt;
    logic [BITS-1:0] ma, mb;
    cnt = 0;
    ma = '0;
    mb = '0;
    bus.i_mul_finished = 1'b0;
    bus.i_mul_product  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_mul_finished = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.i_mul_finished = 1'b1;
          bus.i_mul_product  = PW'(ma) * PW'(mb);
        end
      end else if (bus.o_mul_start && !hang) begin
        ma  = bus.o_mul_multiplicand;
        mb  = bus.o_mul_multiplier;
        cnt = int'($urandom_range(6, 1));
      end else if (bus.o_grant == '0 && $urandom_range(7, 0) == 0) begin
        bus.i_mul_finished = 1'b1;
        bus.i_mul_product  = PW'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard on every completion and checks grant/start against the queue head.
  initial begin
    int age, starts;
    bit prev_fin, comp;
    age = 0;
    starts = 0;
    prev_fin = 1'b0;
    forever begin
      @(negedge clk);
      comp = (bus.o_done != '0) || (bus.o_error != '0);
      if (comp) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", int'(bus.o_done | bus.o_error), 0);
        end else begin
          exp_t e;
          logic [REQ-1:0] oh;
          e  = exp_q.pop_front();
          oh = REQ'(1) << e.client;
          check("done_vec",  int'(bus.o_done),  e.is_err ? 0 : int'(oh));
          check("error_vec", int'(bus.o_error), e.is_err ? int'(oh) : 0);
          check("product",   int'(bus.o_product), int'(e.prod));
          check("start_count", starts, 1);
          if (e.is_err) check("timeout_cycles", age, int'(TO) + 1);
          else          check("done_after_finished", int'(prev_fin), 1);
        end
        starts = 0;
      end else if (bus.o_grant == '0) begin
        starts = 0;
      end

      if (bus.o_grant != '0) age++;
      else                   age = 0;

      if (bus.o_grant != '0 || bus.o_mul_start) begin
        check("start_first_cycle_only", int'(bus.o_mul_start), int'(age == 1));
        if (exp_q.size() == 0) begin
          check("grant_without_request", int'(bus.o_grant), 0);
        end else begin
          check("grant_onehot", int'(bus.o_grant), int'(REQ'(1) << exp_q[0].client));
          if (bus.o_mul_start) begin
            starts++;
            check("mul_multiplicand", int'(bus.o_mul_multiplicand), int'(exp_q[0].a));
            check("mul_multiplier",   int'(bus.o_mul_multiplier),   int'(exp_q[0].b));
          end
        end
      end
      prev_fin = bus.i_mul_finished;
    end
  end

  // Reset pulse spanning one edge; the model forgets all history.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_request = '0;
    @(negedge clk);
    rst = 1'b0;
    hang = 1'b0;
    exp_q.delete();
    mdl_ptr  = 0;
    mdl_last = '0;
    check("rst_grant",   int'(bus.o_grant), 0);
    check("rst_done",    int'(bus.o_done), 0);
    check("rst_error",   int'(bus.o_error), 0);
    check("rst_product", int'(bus.o_product), 0);
    check("rst_start",   int'(bus.o_mul_start), 0);
    check("rst_ops",     int'({bus.o_mul_multiplicand, bus.o_mul_multiplier}), 0);
  endtask

  // Predict service order round-robin, then hold requests until each client is answered.
  task automatic run_batch(input logic [REQ-1:0] mask, input logic [REQ*BITS-1:0] a,
                           input logic [REQ*BITS-1:0] b, input bit hng);
    logic [REQ-1:0] m;
    int cyc;
    m = mask;
    while (m != '0) begin
      for (int i = 0; i < int'(REQ); i++) begin
        int idx;
        idx = (mdl_ptr + i) % int'(REQ);
        if (m[idx]) begin
          exp_t e;
          e.client = idx;
          e.is_err = hng;
          e.a      = a[idx*BITS +: BITS];
          e.b      = b[idx*BITS +: BITS];
          e.prod   = hng ? mdl_last : PW'(e.a) * PW'(e.b);
          if (!hng) mdl_last = e.prod;
          exp_q.push_back(e);
          m[idx]  = 1'b0;
          mdl_ptr = (idx + 1) % int'(REQ);
          break;
        end
      end
    end
    @(negedge clk);
    hang = hng;
    bus.i_multiplicand = a;
    bus.i_multiplier   = b;
    bus.i_request      = mask;
    cyc = 0;
    while (bus.i_request != '0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < int'(REQ); k++) begin
        if (bus.o_done[k] || bus.o_error[k]) begin
          bus.i_request[k] = 1'b0;
        end else if (bus.o_grant[k]) begin
          bus.i_multiplicand[k*BITS +: BITS] = BITS'($urandom);
          bus.i_multiplier[k*BITS +: BITS]   = BITS'($urandom);
        end
      end
    end
    check("batch_served", int'(bus.i_request), 0);
    @(negedge clk);
    hang = 1'b0;
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Directed scenarios followed by random batches.
  initial begin
    int cyc;
    bus.i_request      = '0;
    bus.i_multiplicand = '0;
    bus.i_multiplier   = '0;
    rst = 1'b1;
    do_reset();

    run_batch(4'b0100, {4'd0, 4'd7, 4'd0, 4'd0}, {4'd0, 4'd9, 4'd0, 4'd0}, 1'b0);
    check("single_product", int'(bus.o_product), 63);

    do_reset();
    run_batch(4'b1111, {4'd15, 4'd5, 4'd3, 4'd1}, {4'd15, 4'd6, 4'd4, 4'd2}, 1'b0);

    run_batch(4'b0010, {4'd0, 4'd0, 4'd6, 4'd0}, {4'd0, 4'd0, 4'd7, 4'd0}, 1'b0);
    run_batch(4'b1001, {4'd11, 4'd0, 4'd0, 4'd13}, {4'd3, 4'd0, 4'd0, 4'd2}, 1'b0);

    run_batch(4'b0001, {4'd0, 4'd0, 4'd0, 4'd5}, {4'd0, 4'd0, 4'd0, 4'd5}, 1'b0);
    check("operand_change_product", int'(bus.o_product), 25);

    run_batch(4'b0100, {4'd0, 4'd9, 4'd0, 4'd0}, {4'd0, 4'd9, 4'd0, 4'd0}, 1'b1);
    check("timeout_product_held", int'(bus.o_product), 25);

    // Reset while the multiplier is busy: the job vanishes without a pulse.
    begin
      exp_t e;
      e.client = 1;
      e.is_err = 1'b0;
      e.a = 4'd4;
      e.b = 4'd4;
      e.prod = 8'd16;
      exp_q.push_back(e);
    end
    @(negedge clk);
    hang = 1'b1;
    bus.i_multiplicand = {4'd0, 4'd0, 4'd4, 4'd0};
    bus.i_multiplier   = {4'd0, 4'd0, 4'd4, 4'd0};
    bus.i_request      = 4'b0010;
    cyc = 0;
    while (bus.o_grant == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("midbusy_granted", int'(bus.o_grant), 2);
    repeat (3) @(negedge clk);
    do_reset();
    repeat (2) @(negedge clk);
    check("post_reset_no_done", int'(bus.o_done | bus.o_error), 0);
    run_batch(4'b1000, {4'd15, 4'd0, 4'd0, 4'd0}, {4'd15, 4'd0, 4'd0, 4'd0}, 1'b0);
    check("post_reset_product", int'(bus.o_product), 225);

    for (int n = 0; n < 40; n++) begin
      logic [REQ-1:0] mask;
      mask = REQ'($urandom_range(15, 1));
      run_batch(mask, (REQ*BITS)'($urandom), (REQ*BITS)'($urandom), $urandom_range(9, 0) == 0);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound on simulation time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/multiplier_arbiter.md
Name: multiplier_arbiter

Overview:
Round-robin arbiter and sequencer that shares one sequential Multiplier between REQUESTERS clients. It accepts per-client multiply requests and grants one at a time. For the granted client it drives the multiplier's start/operand inputs, waits for the finished pulse, and returns the product with a one-cycle done pulse. It sits between the datapath clients and the single Multiplier instance.

Parameters:
BITS, 4, operand width; product is 2*BITS.
REQUESTERS, 4, number of clients (>= 2).
TIMEOUT, 64, max cycles in BUSY before abort (must exceed multiplier latency).

Ports:
i_clock  in  1  system clock, rising edge.
i_reset  in  1  synchronous, active-high reset.
i_request  in  REQUESTERS  per-client request level.
i_multiplicand  in  REQUESTERS*BITS  client k operand at [k*BITS +: BITS].
i_multiplier  in  REQUESTERS*BITS  client k operand at [k*BITS +: BITS].
o_grant  out  REQUESTERS  one-hot; bit k high while client k owns the multiplier.
o_done  out  REQUESTERS  one-cycle pulse to the owning client; o_product valid that cycle.
o_error  out  REQUESTERS  one-cycle pulse instead of o_done on timeout.
o_product  out  2*BITS  registered result; held until next completion.
o_mul_start  out  1  start strobe to Multiplier.
o_mul_multiplicand  out  BITS  latched operand to Multiplier.
o_mul_multiplier  out  BITS  latched operand to Multiplier.
i_mul_finished  in  1  Multiplier completion pulse.
i_mul_product  in  2*BITS  Multiplier result, valid with i_mul_finished.

Behaviour:
- Reset (sync, every i_reset edge, any state): state=IDLE; o_grant, o_done, o_error, o_mul_start = 0; o_product, o_mul_* operands = 0; round-robin pointer = 0; timeout counter = 0. The same i_reset resets the Multiplier; an in-flight job is dropped with no done/error pulse.
- States: IDLE, START, BUSY, DONE.
- IDLE: if i_request != 0, choose the first asserted index scanning pointer, pointer+1, ... mod REQUESTERS. Next edge: o_grant = onehot(winner); latch that client's operands into o_mul_*; o_mul_start=1; go to START. No request: stay IDLE, outputs 0.
- START: o_mul_start high exactly this one cycle. Next edge: o_mul_start=0, counter=0, go to BUSY.
- BUSY: counter increments each cycle.
  - On i_mul_finished=1: o_product <= i_mul_product; o_done[winner]=1 next cycle; go to DONE.
  - If counter reaches TIMEOUT-1 without finished: o_error[winner]=1 next cycle; o_product unchanged; go to DONE.
  - If finished and timeout coincide, finished wins.
- DONE: done/error pulse visible this cycle only; o_grant=0. Next edge: pointer = (winner+1) mod REQUESTERS; go to IDLE.
- Latency: request seen in IDLE at edge T -> start high T+1..T+2 -> done = finished edge + 1. Minimum back-to-back spacing is 1 IDLE cycle between jobs.
- Operands are latched at grant; client changes after grant have no effect. Request deasserted while granted does not abort; the job completes and still pulses o_done.
- Client must drop i_request in the o_done cycle, otherwise it re-enters arbitration at the lowest priority (pointer already past it).
- i_mul_finished outside BUSY is ignored.
- Fairness: any continuously asserted request is served within REQUESTERS jobs.

Test Plan:
- Single client: reset, req[2]=1 with 7*9 -> grant=4'b0100, one start pulse, o_done[2] pulse, o_product=63; all other done bits 0.
- All four request simultaneously after reset (operands 1*2, 3*4, 5*6, 15*15) -> served in order 0,1,2,3; products 2, 12, 30, 225; exactly one done pulse each.
- Pointer fairness: client 1 served, then req 0 and 3 together -> client 3 first, then client 0.
- Operand change after grant (5*5 changed to 2*2 during BUSY) -> product 25.
- Timeout: Multiplier model never asserts finished, TIMEOUT=8 -> o_error[k] pulse 8 cycles after BUSY entry, no o_done, o_product unchanged, returns to IDLE.
- Reset mid-BUSY -> next cycle all outputs 0, no done pulse; a fresh req[3] with 15*15 completes with 225.
